multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle RV32I core (riscy32_multi).
- Sequences one shared ALU, one unified instruction/data memory port and the IR/PC/ALUOut/Data registers over 3-5 cycles per instruction.
- Reuses the single-cycle core's op/funct3/funct7 decode and {N,Z,C,V} flag conventions.
- Adds a memory ready handshake, an illegal-opcode trap state and a retired-instruction counter.

---
 rtl/riscy_pkg.sv | 67 ++++++
 rtl/multicycle_control_branch_unit.sv | 32 +++
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscy_pkg.sv
// Shared types and encodings for the riscy32 cores.
// State enum, opcodes, mux selects and ALU codes.
package riscy_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h8;

  // Immediate format implied by the opcode.
  function automatic logic [2:0] imm_sel(
    input logic [6:0] op
  );
    logic [2:0] s;
    s = IMM_I;
    unique case (1'b1)
      (op == OP_STORE):  s = IMM_S;
      (op == OP_BRANCH): s = IMM_B;
      (op == OP_LUI):    s = IMM_U;
      (op == OP_JAL):    s = IMM_J;
      default:           s = IMM_I;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_branch_unit.sv
// Branch condition evaluation from funct3 and ALU flags.
// Ports: funct3, flags {N,Z,C,V} in; taken out.
module branch_unit
  import riscy_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  // Unsigned compare: C set means no borrow, i.e. a >= b.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'd0:    taken = z;
      3'd1:    taken = ~z;
      3'd4:    taken = n ^ v;
      3'd5:    taken = ~(n ^ v);
      3'd6:    taken = ~c;
      3'd7:    taken = c;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core.
// Ports: clk, reset, op/funct3/funct7, flags, mem_ready in;
//   datapath controls, instr_done, illegal, instret out.
module multicycle_control
  import riscy_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic [3:0]       flags,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t state, next;
  logic   taken;

  branch_unit u_br (
    .funct3 (funct3),
    .flags  (flags),
    .taken  (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= next;
      if (instr_done) instret <= instret + ONE;
    end
  end

  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    ResultSrc  = RES_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          next    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jal target precomputed into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_sel(op);
        unique case (1'b1)
          (op == OP_LOAD),
          (op == OP_STORE):  next = S_MEMADR;
          (op == OP_R):      next = S_EXECUTER;
          (op == OP_I):      next = S_EXECUTEI;
          (op == OP_BRANCH): next = S_BRANCH;
          (op == OP_JAL):    next = S_JAL;
          (op == OP_LUI):    next = S_LUI;
          default:           next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_LOAD) begin
          ImmSrc = IMM_I;
          next   = S_MEMREAD;
        end else begin
          ImmSrc = IMM_S;
          next   = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next       = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = {funct7, funct3};
        next       = S_ALUWB;
      end
      S_EXECUTEI: begin
        // IR[30] only selects srai among the I-type ops.
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_I;
        ALUControl = {(funct3 == 3'd5) ? funct7 : 1'b0,
                      funct3};
        next       = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next       = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_SUB;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_B;
        PCWrite    = taken;
        instr_done = 1'b1;
        next       = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut; ALU forms OldPC+4.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        ImmSrc    = IMM_J;
        next      = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        next    = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        next    = S_TRAP;
      end
      default: next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Per-cycle vector table with a scoreboard queue.
module tb_multicycle_control;

  typedef struct packed {
    logic       rq, mw, ad, ir, pc, rw;
    logic [1:0] a, b;
    logic [3:0] alu;
    logic [2:0] im;
    logic [1:0] rs;
    logic       dn, il;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] fl;
    logic       rdy;
    outs_t      e;
    string      nm;
  } vec_t;

  typedef struct {
    outs_t       e;
    logic [31:0] cnt;
    string       nm;
    int          idx;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [3:0]  flags;
  logic        mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite;
  logic        PCWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        instr_done, illegal;
  logic [31:0] instret;

  int checks = 0;
  int failures = 0;

  vec_t tbl[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .flags      (flags),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .ResultSrc  (ResultSrc),
    .instr_done (instr_done),
    .illegal    (illegal),
    .instret    (instret)
  );

  function automatic outs_t o(
    input logic rq, mw, ad, ir, pc, rw,
    input logic [1:0] a, b,
    input logic [3:0] alu,
    input logic [2:0] im,
    input logic [1:0] rs,
    input logic dn, il
  );
    outs_t r;
    r = '{rq, mw, ad, ir, pc, rw, a, b, alu, im, rs, dn, il};
    return r;
  endfunction

  function automatic outs_t fe(input logic rdy);
    return o(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10,
             4'h0, 3'd0, 2'b10, 0, 0);
  endfunction

  function automatic outs_t dec(input logic [2:0] im);
    return o(0, 0, 0, 0, 0, 0, 2'b01, 2'b01,
             4'h0, im, 2'b00, 0, 0);
  endfunction

  function automatic outs_t awb();
    return o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00,
             4'h0, 3'd0, 2'b00, 1, 0);
  endfunction

  function automatic outs_t mrd();
    return o(1, 0, 1, 0, 0, 0, 2'b00, 2'b00,
             4'h0, 3'd0, 2'b00, 0, 0);
  endfunction

  function automatic outs_t trp();
    return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b00,
             4'h0, 3'd0, 2'b00, 0, 1);
  endfunction

  function automatic outs_t brn(input logic t);
    return o(0, 0, 0, 0, t, 0, 2'b10, 2'b00,
             4'h8, 3'd2, 2'b00, 1, 0);
  endfunction

  task automatic v(
    input logic rst,
    input logic [6:0] op_i,
    input logic [2:0] f3,
    input logic f7,
    input logic [3:0] fl,
    input logic rdy,
    input outs_t e,
    input string nm
  );
    vec_t t;
    t.rst = rst; t.op = op_i; t.f3 = f3;
    t.f7 = f7; t.fl = fl; t.rdy = rdy;
    t.e = e; t.nm = nm;
    tbl.push_back(t);
  endtask

  task automatic rtype(
    input logic [2:0] f3, input logic f7,
    input logic [3:0] alu, input string nm
  );
    logic [6:0] R;
    R = 7'b0110011;
    v(0, R, f3, f7, 0, 1, fe(1), {nm, "_fetch"});
    v(0, R, f3, f7, 0, 1, dec(0), {nm, "_dec"});
    v(0, R, f3, f7, 0, 1,
      o(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, alu, 3'd0,
        2'b00, 0, 0), {nm, "_exr"});
    v(0, R, f3, f7, 0, 1, awb(), {nm, "_wb"});
  endtask

  task automatic itype(
    input logic [2:0] f3, input logic f7,
    input logic [3:0] alu, input string nm
  );
    logic [6:0] I;
    I = 7'b0010011;
    v(0, I, f3, f7, 0, 1, fe(1), {nm, "_fetch"});
    v(0, I, f3, f7, 0, 1, dec(0), {nm, "_dec"});
    v(0, I, f3, f7, 0, 1,
      o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, alu, 3'd0,
        2'b00, 0, 0), {nm, "_exi"});
    v(0, I, f3, f7, 0, 1, awb(), {nm, "_wb"});
  endtask

  task automatic br(
    input logic [2:0] f3, input logic [3:0] fl,
    input logic t, input string nm
  );
    logic [6:0] B;
    B = 7'b1100011;
    v(0, B, f3, 0, fl, 1, fe(1), {nm, "_fetch"});
    v(0, B, f3, 0, fl, 1, dec(2), {nm, "_dec"});
    v(0, B, f3, 0, fl, 1, brn(t), {nm, "_br"});
  endtask

  initial begin
    logic [6:0]  LD, ST, JL, LU, BAD;
    logic [31:0] cnt;
    outs_t       act;
    sb_t         s;

    LD = 7'b0000011; ST = 7'b0100011;
    JL = 7'b1101111; LU = 7'b0110111;
    BAD = 7'b1111111;

    reset = 1; op = 0; funct3 = 0; funct7 = 0;
    flags = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

    rtype(3'd0, 1'b0, 4'h0, "add");
    rtype(3'd0, 1'b1, 4'h8, "sub");
    itype(3'd5, 1'b1, 4'hd, "srai");
    itype(3'd4, 1'b1, 4'h4, "xori");

    v(0, LD, 2, 0, 0, 1, fe(1), "lw_fetch");
    v(0, LD, 2, 0, 0, 1, dec(0), "lw_dec");
    v(0, LD, 2, 0, 0, 1,
      o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'h0, 3'd0,
        2'b00, 0, 0), "lw_adr");
    for (int k = 0; k < 3; k++)
      v(0, LD, 2, 0, 0, 0, mrd(), "lw_stall");
    v(0, LD, 2, 0, 0, 1, mrd(), "lw_rd");
    v(0, LD, 2, 0, 0, 1,
      o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'h0, 3'd0,
        2'b01, 1, 0), "lw_wb");

    v(0, ST, 2, 0, 0, 0, fe(0), "sw_fstall");
    v(0, ST, 2, 0, 0, 1, fe(1), "sw_fetch");
    v(0, ST, 2, 0, 0, 1, dec(1), "sw_dec");
    v(0, ST, 2, 0, 0, 1,
      o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'h0, 3'd1,
        2'b00, 0, 0), "sw_adr");
    for (int k = 0; k < 2; k++)
      v(0, ST, 2, 0, 0, 0,
        o(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0, 3'd0,
          2'b00, 0, 0), "sw_stall");
    v(0, ST, 2, 0, 0, 1,
      o(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0, 3'd0,
        2'b00, 1, 0), "sw_wr");

    br(3'd0, 4'b0100, 1, "beq_t");
    br(3'd4, 4'b1001, 0, "blt_nt");
    br(3'd6, 4'b0000, 1, "bltu_t");
    br(3'd2, 4'b0100, 0, "f3_2_nt");
    br(3'd1, 4'b0100, 0, "bne_nt");
    br(3'd5, 4'b1000, 0, "bge_nt");
    br(3'd7, 4'b0010, 1, "bgeu_t");

    v(0, JL, 0, 0, 0, 1, fe(1), "jal_fetch");
    v(0, JL, 0, 0, 0, 1, dec(4), "jal_dec");
    v(0, JL, 0, 0, 0, 1,
      o(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 4'h0, 3'd4,
        2'b00, 0, 0), "jal_jal");
    v(0, JL, 0, 0, 0, 1, awb(), "jal_wb");

    v(0, LU, 0, 0, 0, 1, fe(1), "lui_fetch");
    v(0, LU, 0, 0, 0, 1, dec(3), "lui_dec");
    v(0, LU, 0, 0, 0, 1,
      o(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 4'h0, 3'd3,
        2'b00, 0, 0), "lui_lui");
    v(0, LU, 0, 0, 0, 1, awb(), "lui_wb");

    v(0, BAD, 0, 0, 0, 1, fe(1), "ill_fetch");
    v(0, BAD, 0, 0, 0, 1, dec(0), "ill_dec");
    for (int k = 0; k < 10; k++)
      v(0, BAD, 0, 0, 0, 1, trp(), "ill_trap");
    v(1, BAD, 0, 0, 0, 1, trp(), "ill_rst");
    v(0, LD, 2, 0, 0, 0, fe(0), "post_rst");

    v(0, LD, 2, 0, 0, 1, fe(1), "lwr_fetch");
    v(0, LD, 2, 0, 0, 1, dec(0), "lwr_dec");
    v(0, LD, 2, 0, 0, 1,
      o(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'h0, 3'd0,
        2'b00, 0, 0), "lwr_adr");
    v(0, LD, 2, 0, 0, 0, mrd(), "lwr_stall");
    v(1, LD, 2, 0, 0, 0, mrd(), "lwr_rst");
    v(0, LD, 2, 0, 0, 0, fe(0), "lwr_refetch");
    rtype(3'd0, 1'b0, 4'h0, "add2");

    cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      sb_t p;
      @(posedge clk);
      #1;
      reset     = tbl[i].rst;
      op        = tbl[i].op;
      funct3    = tbl[i].f3;
      funct7    = tbl[i].f7;
      flags     = tbl[i].fl;
      mem_ready = tbl[i].rdy;
      p.e = tbl[i].e; p.cnt = cnt;
      p.nm = tbl[i].nm; p.idx = i;
      sbq.push_back(p);
      if (tbl[i].rst) cnt = 0;
      else if (tbl[i].e.dn) cnt = cnt + 1;

      @(negedge clk);
      s = sbq.pop_front();
      act = {mem_req, MemWrite, AdrSrc, IRWrite,
             PCWrite, RegWrite, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, ResultSrc,
             instr_done, illegal};
      checks++;
      if (act !== s.e) begin
        failures++;
        $display("FAIL %s[%0d] outs act=%h exp=%h",
                 s.nm, s.idx, act, s.e);
      end
      checks++;
      if (instret !== s.cnt) begin
        failures++;
        $display("FAIL %s[%0d] instret act=%0d exp=%0d",
                 s.nm, s.idx, instret, s.cnt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
